// File: rtl/mesm6_ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mesm6_ifetch                                                          |
// | Prefetch queue for the MESM-6 core: fetches words ahead of execution |
// | and hands 24-bit syllables to the decoder with their half-word PC.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mesm6_ifetch #(
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 15,
    parameter int WORD_BITS = 48
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ibus_fetch,
    output logic [ADDR_BITS-1:0]   ibus_addr,
    input  logic [WORD_BITS-1:0]   ibus_input,
    input  logic                   ibus_done,
    input  logic                   redirect,
    input  logic [ADDR_BITS:0]     redirect_pc,
    output logic                   op_valid,
    output logic [WORD_BITS/2-1:0] op_syl,
    output logic [ADDR_BITS:0]     op_pc,
    input  logic                   op_take
);

    localparam int C_PTR_BITS = $clog2(DEPTH);
    localparam int C_CNT_BITS = $clog2(DEPTH + 1);
    localparam int C_SYL_BITS = WORD_BITS / 2;
    localparam logic [C_CNT_BITS-1:0] C_DEPTH = C_CNT_BITS'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   ibus_addr_q, ibus_addr_d;
    logic [ADDR_BITS-1:0]   fetch_addr_q, fetch_addr_d;
    logic [ADDR_BITS:0]     head_pc_q, head_pc_d;
    logic                   half_q, half_d;
    logic [C_PTR_BITS-1:0]  rd_q, rd_d;
    logic [C_PTR_BITS-1:0]  wr_q, wr_d;
    logic [C_CNT_BITS-1:0]  count_q, count_d;
    logic                   discard_q, discard_d;
    logic [WORD_BITS-1:0]   mem_q [DEPTH];

    logic                   w_inflight;
    logic                   w_done;
    logic                   w_take;
    logic                   w_push;
    logic                   w_pop;
    logic [WORD_BITS-1:0]   w_head_word;

    always_comb begin
        w_inflight   = (state_q == ST_FETCH);
        w_done       = w_inflight && ibus_done;
        w_take       = op_take && (count_q != '0);
        // A redirect overrides both the returning word and the consumer.
        w_push       = w_done && !discard_q && !redirect;
        w_pop        = w_take && half_q && !redirect;

        state_d      = state_q;
        ibus_addr_d  = ibus_addr_q;
        fetch_addr_d = fetch_addr_q;
        head_pc_d    = head_pc_q;
        half_d       = half_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        count_d      = count_q;
        discard_d    = discard_q;

        if (redirect) begin
            count_d      = '0;
            rd_d         = wr_q;
            head_pc_d    = redirect_pc;
            half_d       = redirect_pc[0];
            fetch_addr_d = redirect_pc[ADDR_BITS:1];
            discard_d    = w_inflight && !ibus_done;
        end else begin
            if (w_take) begin
                head_pc_d = head_pc_q + (ADDR_BITS+1)'(1);
                half_d    = !half_q;
                if (half_q) begin
                    rd_d = rd_q + C_PTR_BITS'(1);
                end
            end
            if (w_push) begin
                wr_d = wr_q + C_PTR_BITS'(1);
            end
            count_d = count_q + C_CNT_BITS'(w_push) - C_CNT_BITS'(w_pop);
            if (w_done) begin
                discard_d = 1'b0;
                // A dropped word leaves fetch_addr at the redirect target.
                if (!discard_q) begin
                    fetch_addr_d = fetch_addr_q + ADDR_BITS'(1);
                end
            end
        end

        // An open request is held until done; otherwise issue whenever the
        // queue will have room for the word once it returns.
        if (w_inflight && !w_done) begin
            state_d = ST_FETCH;
        end else if (count_d < C_DEPTH) begin
            state_d     = ST_FETCH;
            ibus_addr_d = fetch_addr_d;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ibus_addr_q  <= '0;
            fetch_addr_q <= '0;
            head_pc_q    <= '0;
            half_q       <= 1'b0;
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ibus_addr_q  <= ibus_addr_d;
            fetch_addr_q <= fetch_addr_d;
            head_pc_q    <= head_pc_d;
            half_q       <= half_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            count_q      <= count_d;
            discard_q    <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_q] <= ibus_input;
        end
    end

    assign w_head_word = mem_q[rd_q];
    assign ibus_fetch  = (state_q == ST_FETCH);
    assign ibus_addr   = ibus_addr_q;
    assign op_valid    = (count_q != '0);
    assign op_pc       = head_pc_q;
    assign op_syl      = half_q ? w_head_word[C_SYL_BITS-1:0]
                                : w_head_word[WORD_BITS-1:C_SYL_BITS];

endmodule
`default_nettype wire

// File: tb/tb_mesm6_ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mesm6_ifetch                                                       |
// | Self-checking bench: memory word k = {k, ~k}, syllable stream model. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mesm6_ifetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ibus_fetch;
    logic [14:0] ibus_addr;
    logic [47:0] ibus_input = '0;
    logic        ibus_done = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        op_valid;
    logic [23:0] op_syl;
    logic [15:0] op_pc;
    logic        op_take = 1'b0;

    int errors = 0;
    int checks = 0;
    int lat = 0;
    int bus_cnt = 0;
    int done_cnt = 0;
    int n_taken = 0;
    logic [14:0] addr_log[$];
    logic [15:0] exp_pc = '0;

    always #5 clk = ~clk;

    mesm6_ifetch #(.DEPTH(4), .ADDR_BITS(15), .WORD_BITS(48)) dut (
        .clk(clk), .reset(reset),
        .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr),
        .ibus_input(ibus_input), .ibus_done(ibus_done),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .op_valid(op_valid), .op_syl(op_syl), .op_pc(op_pc),
        .op_take(op_take)
    );

    function automatic logic [47:0] word_of(input logic [14:0] a);
        logic [23:0] k;
        k = {9'd0, a};
        return {k, ~k};
    endfunction

    function automatic logic [23:0] syl_of(input logic [15:0] pc);
        logic [47:0] w;
        w = word_of(pc[15:1]);
        return pc[0] ? w[23:0] : w[47:24];
    endfunction

    // Instruction memory: answers a request after `lat` extra cycles.
    initial begin
        logic [14:0] held;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset || !ibus_fetch) begin
                ibus_done = 1'b0;
                bus_cnt = 0;
            end else begin
                if (bus_cnt == 0) begin
                    held = ibus_addr;
                end else begin
                    checks++;
                    if (ibus_addr !== held) begin
                        errors++;
                        $display("FAIL addr_stable: got %o want %o", ibus_addr, held);
                    end
                end
                if (bus_cnt >= lat) begin
                    ibus_done = 1'b1;
                    ibus_input = word_of(ibus_addr);
                    done_cnt++;
                    addr_log.push_back(ibus_addr);
                    bus_cnt = 0;
                end else begin
                    ibus_done = 1'b0;
                    bus_cnt++;
                end
            end
        end
    end

    // Stream model: after a redirect to P the decoder must see P, P+1, ...
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                exp_pc = '0;
            end else if (redirect) begin
                exp_pc = redirect_pc;
            end else if (op_valid) begin
                checks++;
                if (op_pc !== exp_pc || op_syl !== syl_of(exp_pc)) begin
                    errors++;
                    $display("FAIL stream: got pc=%o syl=%h want pc=%o syl=%h",
                             op_pc, op_syl, exp_pc, syl_of(exp_pc));
                end
                if (op_take) begin
                    exp_pc = exp_pc + 16'd1;
                    n_taken++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_redirect(input logic [15:0] pc);
        cyc(1);
        redirect = 1'b1;
        redirect_pc = pc;
        cyc(1);
        redirect = 1'b0;
    endtask

    task automatic wait_idle;
        bit ok;
        ok = 0;
        op_take = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #3;
            if (!ibus_fetch) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL idle_timeout: got busy want idle"); end
    endtask

    task automatic test_reset;
        lat = 0;
        cyc(3);
        @(negedge clk); #3;
        checks += 4;
        if (ibus_fetch !== 1'b0) begin errors++; $display("FAIL rst_fetch: got %b want 0", ibus_fetch); end
        if (ibus_addr !== 15'd0) begin errors++; $display("FAIL rst_addr: got %o want 0", ibus_addr); end
        if (op_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", op_valid); end
        if (op_pc !== 16'd0) begin errors++; $display("FAIL rst_pc: got %o want 0", op_pc); end
        cyc(1);
        reset = 1'b0;
    endtask

    task automatic test_stream;
        bit seen;
        int bubbles, t0;
        seen = 0; bubbles = 0; t0 = n_taken;
        op_take = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #3;
            if (op_valid) seen = 1;
            else if (seen) bubbles++;
        end
        checks += 3;
        if (!seen) begin errors++; $display("FAIL stream_valid: got 0 want 1"); end
        if (bubbles != 0) begin errors++; $display("FAIL stream_bubbles: got %0d want 0", bubbles); end
        if (n_taken - t0 < 36) begin errors++; $display("FAIL stream_rate: got %0d want >=36", n_taken - t0); end
        cyc(1);
        op_take = 1'b0;
    endtask

    task automatic test_odd_redirect;
        bit ok;
        ok = 0;
        op_take = 1'b0;
        pulse_redirect(16'o11);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #3;
            if (op_valid) begin ok = 1; break; end
        end
        checks += 3;
        if (!ok) begin errors++; $display("FAIL odd_timeout: got no valid want valid"); end
        if (op_pc !== 16'o11) begin errors++; $display("FAIL odd_pc: got %o want 11", op_pc); end
        if (op_syl !== word_of(15'd4)[23:0]) begin errors++; $display("FAIL odd_syl: got %h want %h", op_syl, syl_of(16'o11)); end
        cyc(1);
        op_take = 1'b1;
        cyc(1);
        op_take = 1'b0;
        @(negedge clk); #3;
        checks += 2;
        if (op_pc !== 16'o12) begin errors++; $display("FAIL odd_next_pc: got %o want 12", op_pc); end
        if (op_syl !== word_of(15'd5)[47:24]) begin errors++; $display("FAIL odd_next_syl: got %h want %h", op_syl, syl_of(16'o12)); end
    endtask

    task automatic test_full;
        int d0;
        logic [15:0] pc;
        lat = 0;
        wait_idle();
        pc = 16'(2 * $urandom_range(0, 30000));
        d0 = done_cnt;
        pulse_redirect(pc);
        cyc(20);
        checks += 3;
        if (done_cnt - d0 != 4) begin errors++; $display("FAIL full_fetches: got %0d want 4", done_cnt - d0); end
        if (ibus_fetch !== 1'b0) begin errors++; $display("FAIL full_fetch_low: got %b want 0", ibus_fetch); end
        if (op_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", op_valid); end
        op_take = 1'b1;
        cyc(2);
        op_take = 1'b0;
        d0 = done_cnt;
        cyc(20);
        checks += 2;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL refill_fetches: got %0d want 1", done_cnt - d0); end
        if (ibus_fetch !== 1'b0) begin errors++; $display("FAIL refill_fetch_low: got %b want 0", ibus_fetch); end
    endtask

    task automatic test_stale;
        bit found, ok;
        logic [15:0] tgt;
        found = 0; ok = 0;
        lat = 5;
        op_take = 1'b1;
        tgt = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); #3;
            if (ibus_fetch && bus_cnt == 1) begin found = 1; break; end
        end
        pulse_redirect(tgt);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #3;
            if (op_valid) begin ok = 1; break; end
        end
        checks += 4;
        if (!found) begin errors++; $display("FAIL stale_setup: got no inflight want inflight"); end
        if (!ok) begin errors++; $display("FAIL stale_timeout: got no valid want valid"); end
        if (op_pc !== tgt) begin errors++; $display("FAIL stale_pc: got %o want %o", op_pc, tgt); end
        if (op_syl !== syl_of(tgt)) begin errors++; $display("FAIL stale_syl: got %h want %h", op_syl, syl_of(tgt)); end
        cyc(10);
        lat = 0;
    endtask

    task automatic test_wrap;
        logic [15:0] pcs[$];
        lat = 0;
        wait_idle();
        addr_log.delete();
        cyc(1);
        redirect = 1'b1;
        redirect_pc = 16'o177776;
        cyc(1);
        redirect = 1'b0;
        op_take = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #3;
            if (op_valid && op_take) pcs.push_back(op_pc);
        end
        cyc(1);
        op_take = 1'b0;
        checks += 3;
        if (addr_log.size() < 2 || addr_log[0] !== 15'o77777 || addr_log[1] !== 15'o0) begin
            errors++;
            $display("FAIL wrap_fetch_order: got %0d fetches first %o want 77777 then 0",
                     addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 15'o0);
        end
        if (pcs.size() < 4) begin
            errors++; $display("FAIL wrap_count: got %0d want >=4", pcs.size());
        end else if (pcs[0] !== 16'o177776 || pcs[1] !== 16'o177777 || pcs[2] !== 16'o0 || pcs[3] !== 16'o1) begin
            errors++; $display("FAIL wrap_pc_seq: got %o %o %o %o want 177776 177777 0 1", pcs[0], pcs[1], pcs[2], pcs[3]);
        end
        if (pcs.size() >= 3 && op_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_valid: got %b want 1", op_valid);
        end
    endtask

    task automatic test_collide;
        bit found, ok;
        logic [15:0] tgt;
        found = 0; ok = 0;
        lat = 0;
        tgt = 16'($urandom_range(0, 65535));
        cyc(1);
        op_take = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (ibus_fetch && ibus_done && op_valid) begin found = 1; break; end
        end
        redirect = 1'b1;
        redirect_pc = tgt;
        @(posedge clk); #1;
        redirect = 1'b0;
        op_take = 1'b0;
        checks += 3;
        if (!found) begin errors++; $display("FAIL collide_setup: got no overlap want overlap"); end
        if (op_valid !== 1'b0) begin errors++; $display("FAIL collide_empty: got %b want 0", op_valid); end
        if (op_pc !== tgt) begin errors++; $display("FAIL collide_pc: got %o want %o", op_pc, tgt); end
        op_take = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #3;
            if (op_valid) begin ok = 1; break; end
        end
        checks += 2;
        if (!ok) begin errors++; $display("FAIL collide_timeout: got no valid want valid"); end
        if (op_syl !== syl_of(tgt)) begin errors++; $display("FAIL collide_syl: got %h want %h", op_syl, syl_of(tgt)); end
        cyc(10);
        op_take = 1'b0;
    endtask

    task automatic test_random;
        int t0;
        t0 = n_taken;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) lat = $urandom_range(0, 3);
            op_take = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 29) == 0);
            redirect_pc = 16'($urandom_range(0, 65535));
            cyc(1);
        end
        redirect = 1'b0;
        op_take = 1'b0;
        cyc(2);
        checks++;
        if (n_taken - t0 < 100) begin errors++; $display("FAIL random_progress: got %0d want >=100", n_taken - t0); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_odd_redirect();
        test_full();
        test_stale();
        test_wrap();
        test_collide();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
